// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per clock).
// Define BCD2BIN_CHECK_EN to flag digits > 9 on err and force bin_out to 0 for them.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                busy,
    output logic                done,
    output logic [BIN_W-1:0]    bin_out,
    output logic                err
);

    localparam int HALF  = 4 * DIGITS;
    localparam int SR_W  = 2 * HALF;
    localparam int CNT_W = $clog2(HALF);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_step;
    logic [CNT_W-1:0] cnt;

    // One reverse double-dabble step: shift right, then correct upper-half nibbles >= 8.
    always_comb begin
        sr_step = sr >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_step[HALF + 4*i + 3])
                sr_step[HALF + 4*i +: 4] = sr_step[HALF + 4*i +: 4] - 4'd3;
        end
    end

`ifdef BCD2BIN_CHECK_EN
    logic bad;
    logic digit_bad;

    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9)
                digit_bad = 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    // DONE samples start like IDLE so back-to-back conversions are spaced 4*DIGITS+1 cycles.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            sr      <= '0;
            cnt     <= '0;
`ifdef BCD2BIN_CHECK_EN
            bad     <= 1'b0;
            err     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sr    <= {bcd_in, {HALF{1'b0}}};
                        cnt   <= '0;
                        state <= S_CONV;
                        busy  <= 1'b1;
`ifdef BCD2BIN_CHECK_EN
                        bad   <= digit_bad;
`endif
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_CONV: begin
                    sr  <= sr_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
`ifdef BCD2BIN_CHECK_EN
                        bin_out <= bad ? '0 : sr_step[BIN_W-1:0];
                        err     <= bad;
`else
                        bin_out <= sr_step[BIN_W-1:0];
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized self-checking bench for bcd_to_bin_seq against a decimal-arithmetic model.
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int N_SWEEP = 1500;

    logic              clk = 1'b0;
    logic              reset_p;
    logic              start;
    logic [15:0]       bcd_in;
    logic              busy;
    logic              done;
    logic [BIN_W-1:0]  bin_out;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int v;
        r = '0;
        v = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Drives one isolated conversion and reports what was observed.
    task automatic run_conv(input logic [15:0] bcd, output int lat, output logic [BIN_W-1:0] b,
                            output logic e, output int busy_cyc, output int dones, output bit stable);
        logic [BIN_W-1:0] prev_b;
        logic             prev_e;
        @(negedge clk);
        bcd_in = bcd;
        start  = 1'b1;
        prev_b = bin_out;
        prev_e = err;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        bcd_in   = 16'($urandom);
        lat      = -1;
        b        = '0;
        e        = 1'b0;
        busy_cyc = 0;
        dones    = 0;
        stable   = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cyc++;
            if (done) begin
                dones++;
                lat = k - 1;
                b   = bin_out;
                e   = err;
            end else if (lat < 0 && (bin_out !== prev_b || err !== prev_e)) begin
                stable = 1'b0;
            end
            if (!busy) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_p = 1'b1;
        start   = 1'b0;
        bcd_in  = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (bin_out !== '0) begin n_fail++; $display("FAIL reset_bin got=%0d exp=0", bin_out); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        reset_p = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int vals[$];
        int lat, bc, dn;
        logic [BIN_W-1:0] b;
        logic e;
        bit st;
        vals = '{1234, 9999, 0, 1};
        for (int i = 0; i < 4; i++) vals.push_back(int'($urandom_range(0, 9999)));
        foreach (vals[i]) begin
            run_conv(to_bcd(vals[i]), lat, b, e, bc, dn, st);
            n_checks++; if (b !== 14'(vals[i])) begin n_fail++; $display("FAIL basic_bin in=%0d got=%0d exp=%0d", vals[i], b, vals[i]); end
            n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err in=%0d got=%b exp=0", vals[i], e); end
            n_checks++; if (lat != 16) begin n_fail++; $display("FAIL basic_latency in=%0d got=%0d exp=16", vals[i], lat); end
            n_checks++; if (bc != 17) begin n_fail++; $display("FAIL basic_busy_cycles in=%0d got=%0d exp=17", vals[i], bc); end
            n_checks++; if (dn != 1) begin n_fail++; $display("FAIL basic_done_count in=%0d got=%0d exp=1", vals[i], dn); end
            n_checks++; if (!st) begin n_fail++; $display("FAIL basic_hold in=%0d outputs changed before done", vals[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int t0, t1, cnt;
        logic [BIN_W-1:0] v0, v1;
        t0 = -1; t1 = -1; cnt = 0; v0 = '0; v1 = '0;
        @(negedge clk);
        bcd_in = 16'h0042;
        start  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 3) bcd_in = 16'h0777;
            if (done) begin
                cnt++;
                if (cnt == 1) begin t0 = k; v0 = bin_out; end
                if (cnt == 2) begin t1 = k; v1 = bin_out; end
            end
            if (k == 34) start = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (cnt != 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", cnt); end
        n_checks++; if (t0 != 17) begin n_fail++; $display("FAIL b2b_first_time got=%0d exp=17", t0); end
        n_checks++; if (t1 != 34) begin n_fail++; $display("FAIL b2b_second_time got=%0d exp=34", t1); end
        n_checks++; if (v0 !== 14'd42) begin n_fail++; $display("FAIL b2b_first_bin got=%0d exp=42", v0); end
        n_checks++; if (v1 !== 14'd777) begin n_fail++; $display("FAIL b2b_second_bin got=%0d exp=777", v1); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle busy=%b done=%b exp=0/0", busy, done); end
    endtask

    task automatic test_ignore_start;
        int cnt, t;
        logic [BIN_W-1:0] v;
        cnt = 0; t = -1; v = '0;
        @(negedge clk);
        bcd_in = 16'h0555;
        start  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin cnt++; t = k; v = bin_out; end
            start  = (k <= 15) ? 1'($urandom_range(0, 1)) : 1'b0;
            bcd_in = 16'($urandom);
        end
        n_checks++; if (cnt != 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", cnt); end
        n_checks++; if (t != 17) begin n_fail++; $display("FAIL ignore_done_time got=%0d exp=17", t); end
        n_checks++; if (v !== 14'd555) begin n_fail++; $display("FAIL ignore_bin got=%0d exp=555", v); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        int lat, bc, dn, stray;
        logic [BIN_W-1:0] b;
        logic e;
        bit st;
        stray = 0;
        @(negedge clk);
        bcd_in = 16'h5678;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
        reset_p = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
        n_checks++; if (bin_out !== '0) begin n_fail++; $display("FAIL abort_bin got=%0d exp=0", bin_out); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err got=%b exp=0", err); end
        @(negedge clk);
        reset_p = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL abort_no_done got=%0d busy/done cycles exp=0", stray); end
        run_conv(16'h0100, lat, b, e, bc, dn, st);
        n_checks++; if (b !== 14'd100) begin n_fail++; $display("FAIL abort_next_bin got=%0d exp=100", b); end
        n_checks++; if (lat != 16) begin n_fail++; $display("FAIL abort_next_latency got=%0d exp=16", lat); end
    endtask

    task automatic test_check_en;
        int lat, bc, dn;
        logic [BIN_W-1:0] b;
        logic e;
        bit st;
        run_conv(16'h12A4, lat, b, e, bc, dn, st);
        n_checks++; if (lat != 16) begin n_fail++; $display("FAIL invalid_latency got=%0d exp=16", lat); end
`ifdef BCD2BIN_CHECK_EN
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL invalid_err got=%b exp=1", e); end
        n_checks++; if (b !== '0) begin n_fail++; $display("FAIL invalid_bin got=%0d exp=0", b); end
`else
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL invalid_err_tied got=%b exp=0", e); end
`endif
        run_conv(16'h0010, lat, b, e, bc, dn, st);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL recover_err got=%b exp=0", e); end
        n_checks++; if (b !== 14'd10) begin n_fail++; $display("FAIL recover_bin got=%0d exp=10", b); end
    endtask

    // Streams conversions with start held high; the next value is presented during each DONE cycle.
    task automatic test_sweep;
        int exp_q[$];
        int sent, got, last, cyc, n, exp_v, bad_bin, bad_gap;
        sent = 0; got = 0; last = -1; cyc = 0; bad_bin = 0; bad_gap = 0;
        @(negedge clk);
        n = 0;
        bcd_in = to_bcd(n);
        exp_q.push_back(n);
        sent  = 1;
        start = 1'b1;
        while (got < N_SWEEP && cyc < N_SWEEP * 17 + 100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                exp_v = exp_q.pop_front();
                n_checks++;
                if (bin_out !== 14'(exp_v) || err !== 1'b0) begin
                    n_fail++;
                    if (bad_bin++ < 5) $display("FAIL sweep_bin got=%0d err=%b exp=%0d err=0", bin_out, err, exp_v);
                end
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last != 17) begin
                        n_fail++;
                        if (bad_gap++ < 5) $display("FAIL sweep_spacing got=%0d exp=17", cyc - last);
                    end
                end
                last = cyc;
                got++;
                if (sent < N_SWEEP) begin
                    n = (sent == 1) ? 9999 : int'($urandom_range(0, 9999));
                    bcd_in = to_bcd(n);
                    exp_q.push_back(n);
                    sent++;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        n_checks++; if (got != N_SWEEP) begin n_fail++; $display("FAIL sweep_count got=%0d exp=%0d", got, N_SWEEP); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset_p = 1'b1;
        start   = 1'b0;
        bcd_in  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_check_en();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
